// File: rtl/clk_reset_ctrl_pkg.sv
// rtl/clk_reset_ctrl_pkg.sv - state encodings and default parameters for the cpu clock/reset controller
package clk_reset_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 16;
  localparam int DEF_RESET_HOLD_CYCLES  = 8;
  localparam int DEF_STALL_TIMEOUT      = 1024;
  localparam int DEF_CNT_W              = 16;

  localparam logic [7:0] LOCK_LOSS_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == LOCK_LOSS_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clk_reset_ctrl_sync_2ff.sv
// rtl/clk_reset_ctrl_sync_2ff.sv - 1-bit two-flop synchroniser, async reset to 0
module clk_reset_ctrl_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_reset_ctrl.sv
// rtl/clk_reset_ctrl.sv - PLL-lock gated cpu reset sequencer with stall-aware clock enable and watchdog
import clk_reset_ctrl_pkg::*;

module clk_reset_ctrl #(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int STALL_TIMEOUT      = DEF_STALL_TIMEOUT,
  parameter int CNT_W              = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       mem_stall,
  output logic       cpu_reset,
  output logic       cpu_clk_en,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam bit               WDOG_EN     = (STALL_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST  = WDOG_EN ? CNT_W'(STALL_TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic [7:0]       lock_loss_q, lock_loss_d;
  logic             lock_s;
  logic             lock_lost;

  clk_reset_ctrl_sync_2ff u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d_i (pll_locked),
    .q_o (lock_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      cpu_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_loss_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_loss_q <= lock_loss_d;
    end
  end

  // Lock loss is tested before the stall watchdog so it wins in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = '0;
    lock_lost   = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d   = ST_WAIT_LOCK;
          lock_lost = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d   = ST_WAIT_LOCK;
          lock_lost = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d   = ST_WAIT_LOCK;
          lock_lost = 1'b1;
        end else if (WDOG_EN && mem_stall) begin
          if (stall_cnt_q == STALL_LAST) state_d = ST_FAULT;
          else stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_WAIT_LOCK;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    cpu_clk_en  = (state_q == ST_RUN) & ~mem_stall;
    cpu_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
    lock_loss_d = lock_lost ? sat_inc8(lock_loss_q) : lock_loss_q;
  end

  assign cpu_reset     = cpu_reset_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign lock_loss_cnt = lock_loss_q;
  assign state         = state_q;

endmodule
